// File: rtl/synthesizer_top.sv
// synthesizer_top - polyphonic wavetable synthesizer core.
//
// An Avalon-MM slave takes note-on/off and waveform-select commands. A bank
// of phase-accumulator voices is summed once per sample tick. The mix is
// published on an Avalon-ST source, a debug bus and an optional 1-bit
// delta-sigma DAC pin.
//
// Ports:
//   clk               system clock, rising edge
//   reset             synchronous, active-low reset
//   avs_s0_write      command strobe (one command per high cycle)
//   avs_s0_read       status read strobe
//   avs_s0_writedata  command: [15]=on/off, [14:8]=MIDI note, [7:0]=velocity (ignored)
//   avs_s0_readdata   status: {22'b0, waveform[1:0], active voice count[7:0]}
//   o_dac_out         delta-sigma bitstream (0 unless SYNTHESIZER_DAC_EN)
//   aso_ss0_data      current sample, sign-extended to 32 bits
//   aso_ss0_valid     one-cycle pulse per new sample
//   current_out       current mixed sample, 24-bit signed
//
// Build option: define SYNTHESIZER_DAC_EN to enable the first-order
// delta-sigma modulator; otherwise o_dac_out is tied low.
module synthesizer_top #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SAMPLE_HZ  = 96_000,
  parameter int unsigned NUM_VOICES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_s0_write,
  input  logic        avs_s0_read,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        o_dac_out,
  output logic [31:0] aso_ss0_data,
  output logic        aso_ss0_valid,
  output logic [23:0] current_out
);

  localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2
  } wave_e;

  // Top-octave (octave 10) phase increments, one per semitone, evaluated at
  // elaboration from the equal-tempered formula for the configured rate.
  function automatic logic [11:0][31:0] build_tune();
    logic [11:0][31:0] t;
    real r;
    t = '0;
    for (int unsigned s = 0; s < 12; s++) begin
      r = 440.0 * (2.0 ** ((51.0 + real'(s)) / 12.0)) * 4294967296.0 / real'(SAMPLE_HZ);
      t[s] = $rtoi(r);
    end
    return t;
  endfunction

  // Quarter-wave sine: entry i = round(32767 * sin(pi/2 * i/63)), so entry 0
  // is 0 and entry 63 is the 32767 peak. Taylor series keeps this to plain
  // real arithmetic at elaboration.
  function automatic logic [63:0][15:0] build_sine();
    logic [63:0][15:0] t;
    real x, term, acc;
    t = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      x    = 1.57079632679489661923 * real'(i) / 63.0;
      term = x;
      acc  = x;
      for (int unsigned k = 1; k < 12; k++) begin
        term = -term * x * x / real'((2 * k) * (2 * k + 1));
        acc  = acc + term;
      end
      t[i] = 16'($rtoi(32767.0 * acc + 0.5));
    end
    return t;
  endfunction

  localparam logic [11:0][31:0] TUNE = build_tune();
  localparam logic [63:0][15:0] SINE = build_sine();

  // Voice state
  logic [NUM_VOICES-1:0] r_active;
  logic [6:0]            r_note  [NUM_VOICES];
  logic [31:0]           r_phase [NUM_VOICES];
  logic [31:0]           r_inc   [NUM_VOICES];
  wave_e                 r_wave;
  logic [DIV_W-1:0]      r_div;

  // Command decode
  logic                  w_on;
  logic [6:0]            w_note;
  logic [3:0]            w_oct;
  logic [3:0]            w_sem;
  logic [31:0]           w_inc;
  logic [NUM_VOICES-1:0] w_match;
  logic                  w_hit;
  logic                  w_has_free;
  logic [VW-1:0]         w_free_idx;
  logic [7:0]            w_count;
  logic                  w_tick;
  logic signed [15:0]    w_vsamp [NUM_VOICES];
  logic signed [23:0]    w_mix;
  wave_e                 w_wave_next;
  logic                  w_unused_bits;

  assign w_unused_bits = ^{avs_s0_writedata[31:16], avs_s0_writedata[7:0]};

  assign w_on   = avs_s0_writedata[15];
  assign w_note = avs_s0_writedata[14:8];
  assign w_oct  = 4'(w_note / 7'd12);
  assign w_sem  = 4'(w_note % 7'd12);
  assign w_inc  = TUNE[w_sem] >> (4'd10 - w_oct);
  assign w_tick = (r_div == DIV_W'(DIV - 1));

  always_comb begin
    w_wave_next = WAVE_SINE;
    case (r_wave)
      WAVE_SINE:   w_wave_next = WAVE_SQUARE;
      WAVE_SQUARE: w_wave_next = WAVE_SAW;
      default:     w_wave_next = WAVE_SINE;
    endcase
  end

  // Duplicate detection, lowest free slot and active count
  always_comb begin
    w_match    = '0;
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_count    = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      w_match[v] = r_active[v] && (r_note[v] == w_note);
      w_count    = w_count + 8'(r_active[v]);
    end
    // Scan downward so the last hit is the lowest free index.
    for (int unsigned v = NUM_VOICES; v > 0; v--) begin
      if (!r_active[v-1]) begin
        w_has_free = 1'b1;
        w_free_idx = VW'(v - 1);
      end
    end
  end

  assign w_hit = |w_match;

  // Per-voice waveform sample and mix
  always_comb begin
    logic [5:0]  w_idx;
    logic [15:0] w_sine;
    w_mix = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      w_idx  = r_phase[v][30] ? ~r_phase[v][29:24] : r_phase[v][29:24];
      w_sine = SINE[w_idx];
      case (r_wave)
        WAVE_SQUARE: w_vsamp[v] = r_phase[v][31] ? 16'sh8000 : 16'sh7FFF;
        WAVE_SAW:    w_vsamp[v] = {~r_phase[v][31], r_phase[v][30:16]};
        default:     w_vsamp[v] = r_phase[v][31] ? -$signed(w_sine) : $signed(w_sine);
      endcase
      if (r_active[v]) begin
        w_mix = w_mix + 24'(w_vsamp[v]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_active        <= '0;
      r_wave          <= WAVE_SINE;
      r_div           <= '0;
      current_out     <= '0;
      aso_ss0_data    <= '0;
      aso_ss0_valid   <= 1'b0;
      avs_s0_readdata <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_note[v]  <= '0;
        r_phase[v] <= '0;
        r_inc[v]   <= '0;
      end
    end else begin
      aso_ss0_valid <= w_tick;
      if (w_tick) begin
        r_div        <= '0;
        current_out  <= w_mix;
        aso_ss0_data <= {{8{w_mix[23]}}, w_mix};
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (r_active[v]) begin
            r_phase[v] <= r_phase[v] + r_inc[v];
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end

      // Sampled from pre-write state, so a simultaneous write is not visible.
      if (avs_s0_read) begin
        avs_s0_readdata <= {22'b0, r_wave, w_count};
      end

      if (avs_s0_write) begin
        if (w_on) begin
          if (w_note == 7'd0) begin
            r_wave <= w_wave_next;
          end else if (!w_hit && w_has_free) begin
            // The slot is free, so the tick advance above never touches it.
            r_active[w_free_idx] <= 1'b1;
            r_note[w_free_idx]   <= w_note;
            r_inc[w_free_idx]    <= w_inc;
            r_phase[w_free_idx]  <= '0;
          end
        end else if (w_note == 7'd127) begin
          r_active <= '0;
        end else if (w_note != 7'd0) begin
          for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (w_match[v]) begin
              r_active[v] <= 1'b0;
            end
          end
        end
      end
    end
  end

`ifdef SYNTHESIZER_DAC_EN
  // Bit 24 holds the carry of the last accumulation; the low 24 bits are
  // the running integrator fed with current_out in offset binary.
  logic [24:0] r_integ;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_integ <= '0;
    end else begin
      r_integ <= {1'b0, r_integ[23:0]} + {1'b0, ~current_out[23], current_out[22:0]};
    end
  end

  assign o_dac_out = r_integ[24];
`else
  assign o_dac_out = 1'b0;
`endif

endmodule

// File: tb/tb_synthesizer_top.sv
module tb_synthesizer_top;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned SAMPLE_HZ = 96_000;
  localparam int          NV        = 8;
  localparam int          DIV       = CLK_HZ / SAMPLE_HZ;
  localparam real         PI        = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        avs_s0_write = 1'b0;
  logic        avs_s0_read = 1'b0;
  logic [31:0] avs_s0_writedata = '0;
  logic [31:0] avs_s0_readdata;
  logic        o_dac_out;
  logic [31:0] aso_ss0_data;
  logic        aso_ss0_valid;
  logic [23:0] current_out;

  synthesizer_top #(
    .CLK_HZ(CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ),
    .NUM_VOICES(NV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs_s0_write(avs_s0_write),
    .avs_s0_read(avs_s0_read),
    .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_readdata(avs_s0_readdata),
    .o_dac_out(o_dac_out),
    .aso_ss0_data(aso_ss0_data),
    .aso_ss0_valid(aso_ss0_valid),
    .current_out(current_out)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit        m_act  [NV];
  int        m_note [NV];
  bit [31:0] m_ph   [NV];
  bit [31:0] m_inc  [NV];
  int        m_wave;
  int        m_cyc;
  int        m_cur;
  bit        m_valid;
  bit [31:0] m_rd;
  bit [24:0] m_integ;

  task automatic expect_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] tune_inc(input int n);
    real    t;
    longint tf;
    t  = 440.0 * (2.0 ** ((120.0 + real'(n % 12) - 69.0) / 12.0)) * 4294967296.0 / real'(SAMPLE_HZ);
    tf = longint'($floor(t));
    return 32'(tf >> (10 - n / 12));
  endfunction

  function automatic int sine_q(input int idx);
    return int'($floor(32767.0 * $sin(PI / 2.0 * real'(idx) / 63.0) + 0.5));
  endfunction

  function automatic int voice_sample(input int wave, input bit [31:0] ph);
    int idx, v;
    if (wave == 1) return ph[31] ? -32768 : 32767;
    if (wave == 2) return int'({16'b0, ph[31:16]}) - 32768;
    idx = int'({26'b0, ph[29:24]});
    if (ph[30]) idx = 63 - idx;
    v = sine_q(idx);
    return ph[31] ? -v : v;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int v = 0; v < NV; v++) c += int'(m_act[v]);
    return c;
  endfunction

  task automatic model_step(input bit rst_n, input bit w, input bit r, input bit [31:0] d);
    bit tick;
    int mix, n;
    bit found;
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) begin
        m_act[v] = 0; m_note[v] = 0; m_ph[v] = 0; m_inc[v] = 0;
      end
      m_wave = 0; m_cyc = 0; m_cur = 0; m_valid = 0; m_rd = 0; m_integ = 0;
      return;
    end
    tick  = (m_cyc % DIV) == DIV - 1;
    m_cyc++;
    m_integ = {1'b0, m_integ[23:0]} + 25'(m_cur + 8388608);
    m_valid = tick;
    if (r) m_rd = {22'b0, 2'(m_wave), 8'(m_count())};
    if (tick) begin
      mix = 0;
      for (int v = 0; v < NV; v++) if (m_act[v]) mix += voice_sample(m_wave, m_ph[v]);
      m_cur = mix;
      for (int v = 0; v < NV; v++) if (m_act[v]) m_ph[v] = m_ph[v] + m_inc[v];
    end
    if (w) begin
      n = int'(d[14:8]);
      if (d[15]) begin
        if (n == 0) m_wave = (m_wave + 1) % 3;
        else begin
          found = 0;
          for (int v = 0; v < NV; v++) if (m_act[v] && m_note[v] == n) found = 1;
          if (!found) begin
            for (int v = 0; v < NV; v++) begin
              if (!m_act[v]) begin
                m_act[v] = 1; m_note[v] = n; m_ph[v] = 0; m_inc[v] = tune_inc(n);
                break;
              end
            end
          end
        end
      end else if (n == 127) begin
        for (int v = 0; v < NV; v++) m_act[v] = 0;
      end else if (n != 0) begin
        for (int v = 0; v < NV; v++) if (m_act[v] && m_note[v] == n) m_act[v] = 0;
      end
    end
  endtask

  task automatic compare_all();
    expect_eq("current_out", longint'($signed(current_out)), longint'(m_cur));
    expect_eq("aso_ss0_data", longint'($signed(aso_ss0_data)), longint'(m_cur));
    expect_eq("aso_ss0_valid", longint'(aso_ss0_valid), longint'(m_valid));
    expect_eq("avs_s0_readdata", longint'(avs_s0_readdata), longint'(m_rd));
`ifdef SYNTHESIZER_DAC_EN
    expect_eq("o_dac_out", longint'(o_dac_out), longint'(m_integ[24]));
`else
    expect_eq("o_dac_out", longint'(o_dac_out), 0);
`endif
  endtask

  // One clock: drive at negedge, model after posedge, compare at next negedge.
  task automatic cycle(input bit w = 0, input bit r = 0, input bit [31:0] d = '0);
    bit rst_now;
    avs_s0_write     = w;
    avs_s0_read      = r;
    avs_s0_writedata = d;
    rst_now          = reset;
    @(posedge clk);
    model_step(rst_now, w, r, d);
    @(negedge clk);
    avs_s0_write = 1'b0;
    avs_s0_read  = 1'b0;
    compare_all();
  endtask

  task automatic run_to_valid(output int cycles);
    cycles = 0;
    do begin
      cycle();
      cycles++;
    end while (!aso_ss0_valid && cycles < DIV + 10);
    if (!aso_ss0_valid) expect_eq("valid_timeout", cycles, DIV);
  endtask

  task automatic read_status(output bit [31:0] v);
    cycle(0, 1);
    v = avs_s0_readdata;
  endtask

  bit [31:0] st;
  int        cyc;
  int        notes9 [9] = '{21, 30, 33, 45, 50, 55, 62, 84, 100};
  int        ones;

  initial begin
    // Pin the model to hand-computed values
    expect_eq("model_inc_A4", longint'(tune_inc(69)), 19685266);
    expect_eq("model_sine_ph0", voice_sample(0, 32'h0), 0);
    expect_eq("model_sine_peak", voice_sample(0, 32'h4000_0000), 32767);
    expect_eq("model_square_ph0", voice_sample(1, 32'h0), 32767);
    expect_eq("model_saw_ph0", voice_sample(2, 32'h0), -32768);
    expect_eq("model_saw_top", voice_sample(2, 32'hFFFF_0000), 32767);

    // Reset
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle();
    expect_eq("reset_current_out", longint'(current_out), 0);
    reset = 1'b1;
    read_status(st);
    expect_eq("reset_readdata", longint'(st), 0);

    // Tick period with no commands
    run_to_valid(cyc);
    expect_eq("silent_tick_out", longint'(current_out), 0);
    run_to_valid(cyc);
    expect_eq("tick_period", cyc, 520);

    // A4: first tick at phase 0, then one increment later
    cycle(1, 0, 32'h0000_C500);
    run_to_valid(cyc);
    expect_eq("A4_first_tick", longint'($signed(current_out)), 0);
    run_to_valid(cyc);
    expect_eq("A4_second_tick", longint'($signed(current_out)), 817);

    // Waveform cycling while A4 plays
    cycle(1, 0, 32'h0000_8000);
    read_status(st);
    expect_eq("wave_square", longint'(st[9:8]), 1);
    run_to_valid(cyc);
    cycle(1, 0, 32'h0000_8000);
    read_status(st);
    expect_eq("wave_saw", longint'(st[9:8]), 2);
    run_to_valid(cyc);
    cycle(1, 0, 32'h0000_8000);
    read_status(st);
    expect_eq("wave_sine", longint'(st[9:8]), 0);

    // Allocation, duplicate and saturation
    cycle(1, 0, 32'h0000_A864);   // E2 = 40
    cycle(1, 0, 32'h0000_BC64);   // C4 = 60
    cycle(1, 0, 32'h0000_CD64);   // F5 = 77
    cycle(1, 0, 32'h0000_DF64);   // B6 = 95
    cycle(1, 0, 32'h0000_C564);   // A4 again
    read_status(st);
    expect_eq("count_5", longint'(st[7:0]), 5);
    foreach (notes9[i]) cycle(1, 0, {16'b0, 1'b1, 7'(notes9[i]), 8'h40});
    read_status(st);
    expect_eq("count_sat_8", longint'(st[7:0]), 8);
    run_to_valid(cyc);

    // Release handling
    cycle(1, 0, 32'h0000_4A00);   // Off D5, not playing
    read_status(st);
    expect_eq("off_absent", longint'(st[7:0]), 8);
    cycle(1, 0, 32'h0000_450F);   // Off A4, velocity ignored
    read_status(st);
    expect_eq("off_A4", longint'(st[7:0]), 7);
    cycle(1, 0, 32'h0000_0000);   // Off N=0 ignored
    read_status(st);
    expect_eq("off_zero", longint'(st[7:0]), 7);
    cycle(1, 1, 32'h0000_7F00);   // simultaneous read sees pre-write count
    expect_eq("rd_wr_same_cycle", longint'(avs_s0_readdata[7:0]), 7);
    read_status(st);
    expect_eq("all_off", longint'(st[7:0]), 0);
    run_to_valid(cyc);
    run_to_valid(cyc);
    expect_eq("all_off_silent", longint'(current_out), 0);

`ifdef SYNTHESIZER_DAC_EN
    ones = 0;
    repeat (1000) begin
      cycle();
      ones += int'(o_dac_out);
    end
    n_checks++;
    if (ones < 490 || ones > 510) begin
      n_fail++;
      $display("FAIL dac_duty: got %0d ones of 1000, expected about 500", ones);
    end
`endif

    // Randomized commands and reads checked by the model every cycle
    for (int i = 0; i < 30 * DIV; i++) begin
      bit        w, r;
      int        k, n;
      bit [31:0] d;
      w = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 7) == 0);
      k = $urandom_range(0, 15);
      n = (k == 0) ? 0 : (k == 15) ? 127 : 55 + 3 * k;
      if ($urandom_range(0, 19) == 0) n = $urandom_range(0, 127);
      d = $urandom;
      d[15]   = ($urandom_range(0, 2) != 0);
      d[14:8] = 7'(n);
      if (k == 15 && $urandom_range(0, 3) != 0) d[15] = 1'b1;
      cycle(w, r, d);
    end

    // Reset mid-note silences output at the next edge
    cycle(1, 0, 32'h0000_C500);
    cycle(1, 0, 32'h0000_8000);
    run_to_valid(cyc);
    run_to_valid(cyc);
    reset = 1'b0;
    cycle();
    expect_eq("midnote_reset_out", longint'(current_out), 0);
    reset = 1'b1;
    read_status(st);
    expect_eq("midnote_reset_status", longint'(st), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/synthesizer_top.md
# synthesizer_top

Polyphonic wavetable synthesizer core: an Avalon-MM slave accepts note-on/off and waveform-select commands, a bank of phase-accumulator voices is summed once per sample tick, and the mix is published on an Avalon-ST source, a debug bus and a 1-bit delta-sigma DAC pin. It sits between the HPS/DMA command path and the audio output stage.

## Interface
- CLK_HZ, 50_000_000, system clock frequency.
- SAMPLE_HZ, 96_000, output sample rate; tuning table is built for this rate.
- NUM_VOICES, 8, simultaneous voices.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- avs_s0_write  in  1  command strobe, one command per high cycle.
- avs_s0_read  in  1  status read strobe.
- avs_s0_writedata  in  32  command word; only [15:0] used.
- avs_s0_readdata  out  32  status word.
- o_dac_out  out  1  delta-sigma bitstream.
- aso_ss0_data  out  32  current sample, sign-extended.
- aso_ss0_valid  out  1  one-cycle pulse per new sample.
- current_out  out  24  current mixed sample, signed.

## Operation
- Command word: bit15 = on/off, bits[14:8] = MIDI note N, bits[7:0] = velocity (ignored); bits[31:16] ignored.
- On, N=0: waveform select advances sine -> square -> sawtooth -> sine; no voice allocated.
- On, N=1..127: if N already active, ignore; else load N into lowest-index free voice, phase cleared to 0; if no free voice, drop.
- Off, N=127: release all voices. Off, N=0: ignored. Off, other N: release the voice holding N; if none, ignore.
- Phase increment: octave = N/12, semitone = N%12; inc = T[semitone] >> (10 - octave), T[s] = floor(440*2^((120+s-69)/12)*2^32/SAMPLE_HZ). N=69 gives 19685266.
- Per voice, 32-bit phase accumulates inc on every sample tick (wraps modulo 2^32).
- Voice sample, 16-bit signed: square = +32767 if phase[31]=0 else -32768; sawtooth = phase[31:16] - 32768; sine = 64-entry quarter-wave LUT (peak 32767) indexed by phase[29:24], index mirrored when phase[30]=1, negated when phase[31]=1.
- Mix = signed sum of active voices, sign-extended to 24 bits (no overflow possible for NUM_VOICES <= 256); inactive voices contribute 0.
- Waveform change applies to all voices from next tick; phases preserved.
- avs_s0_readdata = {22'b0, waveform[1:0] (0 sine, 1 square, 2 saw), active count [7:0]}.

## Timing
- Reset (reset=0 at a rising edge): all voices inactive, phases 0, waveform sine, tick divider 0, current_out=0, aso_ss0_data=0, aso_ss0_valid=0, avs_s0_readdata=0, o_dac_out=0, DAC integrator 0.
- Command takes effect at the edge where avs_s0_write=1; no wait states.
- Sample tick every CLK_HZ/SAMPLE_HZ cycles (integer division). On tick edge, phases advance and current_out/aso_ss0_data register the mix of the pre-advance phases; aso_ss0_valid is high for the following cycle only. No ready backpressure.
- A voice started k cycles before a tick contributes sample for phase 0 at that tick.
- avs_s0_readdata registered: valid the cycle after avs_s0_read; holds otherwise.
- Simultaneous read and write: read returns pre-write state.
- Reset mid-note silences output at the next edge.

## Configuration
- SYNTHESIZER_DAC_EN defined: first-order delta-sigma on current_out every clock; integrator 25-bit, o_dac_out = carry of integrator + (current_out + 2^23) offset-binary value.
- Not defined: o_dac_out tied to 0, no integrator logic.

## Test plan
- Reset, no commands -> current_out=0, aso_ss0_valid pulses every 520 cycles (50 MHz/96 kHz), readdata count 0.
- On A4 (0x0000C500) -> first tick outputs 0 (sine at phase 0); phase advances 19685266 per tick; period ~218.2 ticks.
- On 0x00008000 three times while A4 plays -> waveform square (+32767/-32768), saw, sine; readdata[9:8] = 1,2,0.
- On A4, E2, C4, F5, B6, then on A4 again -> count=5, duplicate ignored; nine further distinct notes -> count saturates at 8.
- Off D5 (not playing) -> no change; Off A4 with velocity 0x0F -> A4 released, count decrements.
- Off 0x00007F00 -> all voices released, current_out=0 at next tick; with SYNTHESIZER_DAC_EN, o_dac_out duty ~50%.
